// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin channel multiplexer.
// Holds the output-register state encoding and the arbitration mode values.
package rr_mux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned RR_FIXED = 0;
    localparam int unsigned RR_ROUND = 1;

    // Channel index width; a 1-bit index is kept even when N_CH is tiny.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin starting at ptr, or fixed lowest-index priority.
// Produces a one-hot grant and its binary index; all-zero when nothing requests.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned RR_MODE = RR_ROUND,
    localparam int unsigned SEL_W  = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [N_CH-1:0] upper;
    logic [N_CH-1:0] pick;

    always_comb begin
        upper = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            upper[i] = req[i] && (RR_MODE == RR_ROUND) && (SEL_W'(i) >= ptr);
        end
        // Requests at or above ptr win; otherwise wrap around to the lowest request.
        pick = (|upper) ? upper : req;

        grant     = '0;
        grant_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel registered multiplexer with valid/ready on every input and the output.
// One-entry output register sustains one word per cycle when downstream is ready.
module rr_chan_mux
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned RR_MODE = RR_ROUND,
    localparam int unsigned SEL_W  = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  word;
    logic              can_load;
    logic              accept;

    rr_arbiter #(
        .N_CH    (N_CH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        word = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (grant[i]) word = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_load  = (state_q == ST_EMPTY) || out_ready;
    assign in_ready  = rst ? '0 : (grant & {N_CH{can_load}});
    assign accept    = |in_ready;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = word;
            sel_d   = grant_idx;
            if (RR_MODE == RR_ROUND) begin
                ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_chan_mux.sv
// Directed bench for rr_chan_mux: 4-ch round-robin, 4-ch fixed priority, 3-ch round-robin.
// Outputs are sampled 1 time unit after each rising edge.
module tb_rr_chan_mux;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 4-channel round-robin instance
    logic [3:0]  v4, r4;
    logic [31:0] d4;
    logic        ordy4, ov4;
    logic [7:0]  od4;
    logic [1:0]  os4;

    // 4-channel fixed-priority instance
    logic [3:0]  vf, rf;
    logic [31:0] df;
    logic        ordyf, ovf;
    logic [7:0]  odf;
    logic [1:0]  osf;

    // 3-channel round-robin instance
    logic [2:0]  v3, r3;
    logic [23:0] d3;
    logic        ordy3, ov3;
    logic [7:0]  od3;
    logic [1:0]  os3;

    rr_chan_mux #(.WIDTH(8), .N_CH(4), .RR_MODE(1)) u_rr4 (
        .clk (clk), .rst (rst), .in_valid (v4), .in_data (d4), .in_ready (r4),
        .out_valid (ov4), .out_data (od4), .out_sel (os4), .out_ready (ordy4)
    );

    rr_chan_mux #(.WIDTH(8), .N_CH(4), .RR_MODE(0)) u_fix4 (
        .clk (clk), .rst (rst), .in_valid (vf), .in_data (df), .in_ready (rf),
        .out_valid (ovf), .out_data (odf), .out_sel (osf), .out_ready (ordyf)
    );

    rr_chan_mux #(.WIDTH(8), .N_CH(3), .RR_MODE(1)) u_rr3 (
        .clk (clk), .rst (rst), .in_valid (v3), .in_data (d3), .in_ready (r3),
        .out_valid (ov3), .out_data (od3), .out_sel (os3), .out_ready (ordy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out4(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s);
        chk({tag, ".valid"}, 32'(ov4), 32'(v));
        chk({tag, ".data"},  32'(od4), 32'(d));
        chk({tag, ".sel"},   32'(os4), 32'(s));
    endtask

    initial begin
        rst = 1'b1;
        v4 = 4'b1111; d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; ordy4 = 1'b0;
        vf = 4'b0000; df = '0; ordyf = 1'b0;
        v3 = 3'b000;  d3 = '0; ordy3 = 1'b0;

        // Reset held for two edges with every channel requesting
        #1;
        chk("rst_in_ready_comb", 32'(r4), 32'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_in_ready", 32'(r4), 32'h0);
            chk_out4("rst", 1'b0, 8'h00, 2'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(r4), 32'b0001);

        // Round-robin rotation at full throughput
        ordy4 = 1'b1;
        #1;
        chk("rr_ready0", 32'(r4), 32'b0001);
        step(); chk_out4("rr_w0", 1'b1, 8'hA0, 2'd0); chk("rr_ready1", 32'(r4), 32'b0010);
        step(); chk_out4("rr_w1", 1'b1, 8'hA1, 2'd1); chk("rr_ready2", 32'(r4), 32'b0100);
        step(); chk_out4("rr_w2", 1'b1, 8'hA2, 2'd2); chk("rr_ready3", 32'(r4), 32'b1000);
        step(); chk_out4("rr_w3", 1'b1, 8'hA3, 2'd3); chk("rr_ready4", 32'(r4), 32'b0001);
        step(); chk_out4("rr_w4", 1'b1, 8'hA0, 2'd0);

        // Back-pressure: load 0x55 from ch2 (ptr -> 3), then stall five cycles
        v4 = 4'b0100; d4 = {8'hB3, 8'h55, 8'hB1, 8'hB0};
        #1;
        chk("bp_ready_ch2", 32'(r4), 32'b0100);
        step(); chk_out4("bp_load", 1'b1, 8'h55, 2'd2);
        ordy4 = 1'b0; v4 = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_stall_ready", 32'(r4), 32'h0);
            step();
            chk_out4("bp_stall", 1'b1, 8'h55, 2'd2);
        end
        ordy4 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(r4), 32'b1000);
        step(); chk_out4("bp_next_ch3", 1'b1, 8'hB3, 2'd3);
        step(); chk_out4("bp_next_ch0", 1'b1, 8'hB0, 2'd0);

        // Drive ptr to 3 again, stall, then reset mid-transfer
        v4 = 4'b0100; d4 = {8'hB3, 8'hC2, 8'hB1, 8'hB0};
        step(); chk_out4("mr_load", 1'b1, 8'hC2, 2'd2);
        ordy4 = 1'b0; v4 = 4'b1011;
        step(); chk_out4("mr_hold", 1'b1, 8'hC2, 2'd2);
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(r4), 32'h0);
        step(); chk_out4("mr_after_rst", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        chk("mr_ptr0_ready", 32'(r4), 32'b0001);
        step(); chk_out4("mr_first_word", 1'b1, 8'hB0, 2'd0);
        v4 = 4'b0000;

        // Fixed priority: ch1 starves while ch0 requests
        vf = 4'b0011; df = {8'hF3, 8'hF2, 8'hF1, 8'hF0}; ordyf = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("fp_ready", 32'(rf), 32'b0001);
            step();
            chk("fp_valid", 32'(ovf), 32'h1);
            chk("fp_sel",   32'(osf), 32'h0);
            chk("fp_data",  32'(odf), 32'hF0);
        end
        vf = 4'b0010;
        #1;
        chk("fp_ready_ch1", 32'(rf), 32'b0010);
        step();
        chk("fp_sel_ch1",  32'(osf), 32'h1);
        chk("fp_data_ch1", 32'(odf), 32'hF1);
        vf = 4'b0000;
        step();
        chk("fp_drain", 32'(ovf), 32'h0);
        chk("fp_hold_data", 32'(odf), 32'hF1);

        // Three channels: pointer wraps 2 -> 0
        v3 = 3'b111; d3 = {8'h32, 8'h31, 8'h30}; ordy3 = 1'b1;
        #1; chk("n3_ready0", 32'(r3), 32'b001);
        step(); chk("n3_sel0", 32'(os3), 32'd0); chk("n3_data0", 32'(od3), 32'h30);
        chk("n3_ready1", 32'(r3), 32'b010);
        step(); chk("n3_sel1", 32'(os3), 32'd1); chk("n3_data1", 32'(od3), 32'h31);
        chk("n3_ready2", 32'(r3), 32'b100);
        step(); chk("n3_sel2", 32'(os3), 32'd2); chk("n3_data2", 32'(od3), 32'h32);
        chk("n3_ready_wrap", 32'(r3), 32'b001);
        step(); chk("n3_sel3", 32'(os3), 32'd0); chk("n3_data3", 32'(od3), 32'h30);
        step(); chk("n3_sel4", 32'(os3), 32'd1); chk("n3_valid4", 32'(ov3), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised N-channel, W-bit registered channel multiplexer with valid/ready handshakes on every input and on the output.
- Arbitration is selectable between round-robin and fixed priority.
- Successor to the plain 2:1 combinational mux. It adds arbitration state, a one-entry output register and back-pressure.
- Used wherever several FSM-driven producers share one downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- N_CH, 4, number of input channels; legal range 2..16; need not be a power of two.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, derived localparam, max(1, clog2(N_CH)); width of the channel index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_CH  per-channel valid; bit i belongs to channel i.
- in_data  in  N_CH*WIDTH  packed data; channel i at [i*WIDTH +: WIDTH].
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data word.
- out_sel  out  SEL_W  index of the channel the held word came from.
- out_ready  in  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
- While rst=1, in_ready is forced to all-zero combinationally.
- Reset mid-transfer discards the held word; no handshake completes in a reset cycle.
- Output FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Grant g (combinational, one-hot when any in_valid is set, zero otherwise):
  - RR_MODE=1: the first i with in_valid[i]=1, scanning ptr, ptr+1, ... N_CH-1, 0, ... ptr-1.
  - RR_MODE=0: the lowest i with in_valid[i]=1.
- can_load = (state==EMPTY) | out_ready.
- in_ready = g & {N_CH{can_load}}. in_ready must not depend on any in_data bit.
- Accept: an input transfer occurs on channel i when in_valid[i] & in_ready[i].
- On accept:
  - out_data <= channel i data; out_sel <= i; state <= FULL.
  - If RR_MODE=1, ptr <= i+1, wrapping to 0 when i==N_CH-1 (explicit compare, not a power-of-two mask).
- Output transfer: occurs when out_valid & out_ready.
  - If there is no simultaneous accept, state <= EMPTY. out_data and out_sel keep their old values.
- Simultaneous output transfer and accept in one cycle: the new word is loaded and state stays FULL. This gives one word per cycle sustained throughput.
- FULL with out_ready=0: out_data, out_sel, ptr and state all hold. in_ready is all-zero.
- Latency: one cycle from input accept to out_valid=1.
- When no in_valid bit is set, ptr is unchanged.
- In RR_MODE=0, ptr stays at 0 permanently.
- Producers must hold in_valid and in_data until accepted. The block does not check this.

Decomposition:
- Shared package (rr_mux_pkg): state encoding constants (ST_EMPTY=1'b0, ST_FULL=1'b1) and the RR_MODE value constants.
- One sub-module, rr_arbiter: parameters N_CH and RR_MODE; inputs req[N_CH] and ptr[SEL_W]; outputs one-hot grant[N_CH] and binary grant_idx[SEL_W]. It is purely combinational.
- Datapath, output register and pointer update stay in rr_chan_mux.

Test Plan:
- Reset check: set rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. Release rst; in the first cycle after release, in_ready=4'b0001.
- Round-robin rotation (N_CH=4, WIDTH=8, RR_MODE=1): hold out_ready=1 and in_valid=4'b1111 with data ch0..3 = 8'hA0, A1, A2, A3.
  - Required out_sel sequence on consecutive cycles: 0,1,2,3,0; out_data A0,A1,A2,A3,A0.
  - One word per cycle throughout.
- Back-pressure: accept 8'h55 from ch2, then hold out_ready=0 for 5 cycles while in_valid=4'b1011.
  - out_data=8'h55, out_sel=2 and in_ready=0 stay stable for all 5 cycles.
  - Raise out_ready: the next word is from ch3 (ptr=3), the one after from ch0.
- Fixed-priority starvation (RR_MODE=0): in_valid=4'b0011 continuously, out_ready=1 -> out_sel=0 every cycle and ch1 is never granted. Drop in_valid[0] -> out_sel=1 on the next word.
- Non-power-of-two wrap (N_CH=3): in_valid=3'b111 -> out_sel cycles 0,1,2,0,1. The pointer never reaches 3.
- Mid-operation reset: while FULL with out_ready=0, assert rst for 1 cycle -> out_valid=0 and ptr=0 after the edge, and the held word is discarded. The next accepted word comes from the lowest valid channel.
